blk_sched: RTL and testbench

- Per-thread block scheduler in front of the SHA-512 block-creation stage.
- Tracks each thread's computation status and picks the next ready thread by round-robin.
- Issues the one-cycle blk_start/new_comp/thread_num strobe, then waits for that block to end before issuing the next.
- Consumes the per-block save reports (comp_active, procb_active) to decide a thread's next state, and pulses completion when a computation finishes.

---
 rtl/blk_sched.sv | 186 ++++++++++++++++++
 tb/tb_blk_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_sched.sv
// Per-thread block scheduler feeding the SHA-512 block-creation stage.
// Tracks each thread's computation state, picks the next ready thread round-robin,
// issues a one-cycle blk_start strobe and waits for that block to end before
// issuing again. Save reports decide a thread's next state.
// Optional feature: define BLK_SCHED_WATCHDOG_EN to add a 16-bit S_WAIT watchdog
// that aborts a block whose blk_end never arrives.
module blk_sched #(
    parameter int unsigned N_THREADS     = 16,
    parameter int unsigned N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     load_en,
    input  logic [N_THREADS_MSB:0]   load_thread_num,
    input  logic                     load_new,
    input  logic                     eng_ready,
    input  logic                     blk_end,
    input  logic                     save_wr_en,
    input  logic [N_THREADS_MSB:0]   save_thread_num,
    input  logic                     save_comp_active,
    input  logic                     save_procb_active,
    output logic                     blk_start,
    output logic                     new_comp,
    output logic [N_THREADS_MSB:0]   thread_num,
    output logic                     done_en,
    output logic [N_THREADS_MSB:0]   done_thread_num,
    output logic                     idle,
    output logic                     err
);

    localparam int unsigned TW = N_THREADS_MSB + 1;

    typedef enum logic [1:0] {
        T_IDLE,
        T_READY_NEW,
        T_READY_CONT,
        T_WAIT_PROCB
    } thr_state_e;

    typedef enum logic [1:0] {
        S_ARB,
        S_WAIT,
        S_SETTLE
    } fsm_state_e;

    thr_state_e            thr_q [N_THREADS];
    thr_state_e            thr_d [N_THREADS];
    fsm_state_e            fsm_q;
    logic [TW-1:0]         rr_q;
    logic [TW-1:0]         rr_next;
    logic [N_THREADS-1:0]  ready_mask;
    logic                  all_idle;
    logic                  arb_found;
    logic [TW-1:0]         arb_winner;
    logic [31:0]           arb_idx;
    logic                  issue;
    logic                  load_in_range;
    logic                  save_in_range;
    logic                  load_err;
    logic                  save_err;

`ifdef BLK_SCHED_WATCHDOG_EN
    logic [15:0]           wd_q;
`endif

    assign load_in_range = 32'(load_thread_num) < N_THREADS;
    assign save_in_range = 32'(save_thread_num) < N_THREADS;
    assign save_err      = save_wr_en && !save_in_range;

    // Ready mask and all-idle summary from the registered thread states
    always_comb begin
        ready_mask = '0;
        all_idle   = 1'b1;
        for (int unsigned i = 0; i < N_THREADS; i++) begin
            ready_mask[i] = (thr_q[i] == T_READY_NEW) || (thr_q[i] == T_READY_CONT);
            if (thr_q[i] != T_IDLE) all_idle = 1'b0;
        end
    end

    // Round-robin pick: first ready thread at or after rr_q, wrapping to 0
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_idx    = '0;
        for (int unsigned i = 0; i < N_THREADS; i++) begin
            arb_idx = 32'(rr_q) + i;
            if (arb_idx >= N_THREADS) arb_idx = arb_idx - N_THREADS;
            if (!arb_found && ready_mask[arb_idx[TW-1:0]]) begin
                arb_found  = 1'b1;
                arb_winner = arb_idx[TW-1:0];
            end
        end
    end

    assign issue   = (fsm_q == S_ARB) && arb_found && eng_ready;
    assign rr_next = (32'(arb_winner) == N_THREADS - 1) ? '0 : arb_winner + TW'(1);
    assign idle    = (fsm_q == S_ARB) && all_idle;

    // Next thread states: load, then issue (thread goes in flight), then save wins
    always_comb begin
        thr_d    = thr_q;
        load_err = 1'b0;
        if (load_en) begin
            if (!load_in_range) begin
                load_err = 1'b1;
            end else if (save_wr_en && (save_thread_num == load_thread_num)) begin
                // Save and load collide: the save owns the thread this cycle
                load_err = 1'b1;
            end else if (load_new && (thr_q[load_thread_num] == T_IDLE)) begin
                thr_d[load_thread_num] = T_READY_NEW;
            end else if (!load_new && (thr_q[load_thread_num] == T_WAIT_PROCB)) begin
                thr_d[load_thread_num] = T_READY_CONT;
            end else begin
                load_err = 1'b1;
            end
        end
        if (issue) thr_d[arb_winner] = T_IDLE;
        if (save_wr_en && save_in_range) begin
            if (!save_comp_active)      thr_d[save_thread_num] = T_IDLE;
            else if (save_procb_active) thr_d[save_thread_num] = T_READY_CONT;
            else                        thr_d[save_thread_num] = T_WAIT_PROCB;
        end
    end

    // Thread state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < N_THREADS; i++) thr_q[i] <= T_IDLE;
        end else begin
            for (int unsigned i = 0; i < N_THREADS; i++) thr_q[i] <= thr_d[i];
        end
    end

    // Issue FSM with registered strobes, completion pulse and sticky error
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fsm_q           <= S_ARB;
            rr_q            <= '0;
            blk_start       <= 1'b0;
            new_comp        <= 1'b0;
            thread_num      <= '0;
            done_en         <= 1'b0;
            done_thread_num <= '0;
            err             <= 1'b0;
`ifdef BLK_SCHED_WATCHDOG_EN
            wd_q            <= '0;
`endif
        end else begin
            blk_start <= 1'b0;
            done_en   <= save_wr_en && save_in_range && !save_comp_active;
            if (save_wr_en && !save_comp_active) done_thread_num <= save_thread_num;
            if (load_err || save_err) err <= 1'b1;
            case (fsm_q)
                S_ARB: begin
                    if (blk_end) err <= 1'b1;
                    if (issue) begin
                        blk_start  <= 1'b1;
                        thread_num <= arb_winner;
                        new_comp   <= (thr_q[arb_winner] == T_READY_NEW);
                        rr_q       <= rr_next;
                        fsm_q      <= S_WAIT;
`ifdef BLK_SCHED_WATCHDOG_EN
                        wd_q       <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (blk_end) begin
                        fsm_q <= S_SETTLE;
`ifdef BLK_SCHED_WATCHDOG_EN
                    end else if (wd_q == 16'hFFFF) begin
                        // Abandon the block; the in-flight thread is already IDLE
                        err   <= 1'b1;
                        fsm_q <= S_ARB;
                    end else begin
                        wd_q <= wd_q + 16'd1;
`endif
                    end
                end
                S_SETTLE: fsm_q <= S_ARB;
                default:  fsm_q <= S_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_blk_sched.sv
// Directed self-checking bench for blk_sched (16 threads).
module tb_blk_sched;

    localparam int unsigned N_THREADS = 16;
    localparam int unsigned TW        = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          load_en;
    logic [TW-1:0] load_thread_num;
    logic          load_new;
    logic          eng_ready;
    logic          blk_end;
    logic          save_wr_en;
    logic [TW-1:0] save_thread_num;
    logic          save_comp_active;
    logic          save_procb_active;
    logic          blk_start;
    logic          new_comp;
    logic [TW-1:0] thread_num;
    logic          done_en;
    logic [TW-1:0] done_thread_num;
    logic          idle;
    logic          err;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    blk_sched #(
        .N_THREADS(N_THREADS)
    ) u_dut (
        .CLK              (CLK),
        .RST              (RST),
        .load_en          (load_en),
        .load_thread_num  (load_thread_num),
        .load_new         (load_new),
        .eng_ready        (eng_ready),
        .blk_end          (blk_end),
        .save_wr_en       (save_wr_en),
        .save_thread_num  (save_thread_num),
        .save_comp_active (save_comp_active),
        .save_procb_active(save_procb_active),
        .blk_start        (blk_start),
        .new_comp         (new_comp),
        .thread_num       (thread_num),
        .done_en          (done_en),
        .done_thread_num  (done_thread_num),
        .idle             (idle),
        .err              (err)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        load_en           = 1'b0;
        load_thread_num   = '0;
        load_new          = 1'b0;
        blk_end           = 1'b0;
        save_wr_en        = 1'b0;
        save_thread_num   = '0;
        save_comp_active  = 1'b0;
        save_procb_active = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_inputs();
        tick();
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic load(input int t, input logic nw);
        load_en         = 1'b1;
        load_thread_num = TW'(t);
        load_new        = nw;
        tick();
        load_en         = 1'b0;
    endtask

    // Waits (bounded) for blk_start and checks the issued thread and new_comp
    task automatic expect_issue(input string tag, input int t, input logic nc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (blk_start) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_seen"}, 32'(ok), 1);
        check_eq({tag, "_thr"}, 32'(thread_num), 32'(t));
        check_eq({tag, "_new"}, 32'(new_comp), 32'(nc));
    endtask

    // Ends the in-flight block with a save report, then checks the done pulse
    task automatic end_block(input string tag, input int t, input logic comp, input logic procb);
        blk_end           = 1'b1;
        save_wr_en        = 1'b1;
        save_thread_num   = TW'(t);
        save_comp_active  = comp;
        save_procb_active = procb;
        tick();
        clear_inputs();
        check_eq({tag, "_done"}, 32'(done_en), 32'(!comp));
        if (!comp) check_eq({tag, "_dthr"}, 32'(done_thread_num), 32'(t));
    endtask

    int starts;

    initial begin
        eng_ready = 1'b1;
        do_reset();

        // Reset state
        check_eq("rst_start", 32'(blk_start), 0);
        check_eq("rst_idle", 32'(idle), 1);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_done", 32'(done_en), 0);
        check_eq("rst_thr", 32'(thread_num), 0);

        // Two-cycle load-to-start latency
        load(3, 1'b1);
        check_eq("lat_early", 32'(blk_start), 0);
        tick();
        check_eq("lat_start", 32'(blk_start), 1);
        check_eq("lat_thr", 32'(thread_num), 3);
        check_eq("lat_new", 32'(new_comp), 1);
        tick();
        check_eq("lat_pulse", 32'(blk_start), 0);
        check_eq("lat_busy", 32'(idle), 0);
        end_block("t3", 3, 1'b0, 1'b0);
        tick();
        check_eq("t3_idle", 32'(idle), 1);

        // Round-robin over 1,5,9 for two rounds
        do_reset();
        eng_ready = 1'b0;
        load(1, 1'b1);
        load(5, 1'b1);
        load(9, 1'b1);
        check_eq("rr_gated", 32'(blk_start), 0);
        eng_ready = 1'b1;
        expect_issue("rr_a1", 1, 1'b1);
        end_block("rr_a1", 1, 1'b1, 1'b1);
        expect_issue("rr_a5", 5, 1'b1);
        end_block("rr_a5", 5, 1'b1, 1'b1);
        expect_issue("rr_a9", 9, 1'b1);
        end_block("rr_a9", 9, 1'b1, 1'b1);
        expect_issue("rr_b1", 1, 1'b0);
        end_block("rr_b1", 1, 1'b0, 1'b0);
        expect_issue("rr_b5", 5, 1'b0);
        end_block("rr_b5", 5, 1'b0, 1'b0);
        expect_issue("rr_b9", 9, 1'b0);
        end_block("rr_b9", 9, 1'b0, 1'b0);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (blk_start) starts++;
        end
        check_eq("rr_quiet", 32'(starts), 0);
        check_eq("rr_idle", 32'(idle), 1);

        // Parked in WAIT_PROCB until a continuation load
        load(2, 1'b1);
        expect_issue("wp_first", 2, 1'b1);
        end_block("wp_first", 2, 1'b1, 1'b0);
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (blk_start) starts++;
        end
        check_eq("wp_parked", 32'(starts), 0);
        check_eq("wp_notidle", 32'(idle), 0);
        check_eq("wp_noerr", 32'(err), 0);
        load(2, 1'b0);
        expect_issue("wp_cont", 2, 1'b0);
        end_block("wp_cont", 2, 1'b0, 1'b0);

        // Double new-load of a READY_NEW thread
        eng_ready = 1'b0;
        load(4, 1'b1);
        check_eq("dbl_noerr", 32'(err), 0);
        load(4, 1'b1);
        check_eq("dbl_err", 32'(err), 1);
        eng_ready = 1'b1;
        expect_issue("dbl_iss", 4, 1'b1);
        end_block("dbl_iss", 4, 1'b0, 1'b0);

        // Asynchronous reset mid-block clears everything at once
        load(7, 1'b1);
        expect_issue("ar_iss", 7, 1'b1);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check_eq("ar_err", 32'(err), 0);
        check_eq("ar_idle", 32'(idle), 1);
        tick();
        RST = 1'b0;
        tick();

        // Save and load to the same thread: save wins, load dropped
        load(6, 1'b1);
        expect_issue("col_iss", 6, 1'b1);
        load_en         = 1'b1;
        load_thread_num = 4'd6;
        load_new        = 1'b1;
        end_block("col", 6, 1'b1, 1'b1);
        check_eq("col_err", 32'(err), 1);
        expect_issue("col_re", 6, 1'b0);
        end_block("col_re", 6, 1'b0, 1'b0);

        // blk_end while arbitrating is a protocol error
        do_reset();
        blk_end = 1'b1;
        tick();
        blk_end = 1'b0;
        check_eq("arb_end_err", 32'(err), 1);
        check_eq("arb_end_idle", 32'(idle), 1);

        // Withheld blk_end
        do_reset();
        load(7, 1'b1);
        expect_issue("wd_iss", 7, 1'b1);
        load(8, 1'b1);
`ifdef BLK_SCHED_WATCHDOG_EN
        for (int i = 0; i < 66000; i++) begin
            tick();
            if (err) break;
        end
        check_eq("wd_err", 32'(err), 1);
        expect_issue("wd_next", 8, 1'b1);
`else
        for (int i = 0; i < 70000; i++) tick();
        check_eq("wd_noerr", 32'(err), 0);
        check_eq("wd_busy", 32'(idle), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
